// File: rtl/ps2_key_rx_if.sv
// Signal bundle between the PS/2 pins, the receiver and the keyboard handler.
// The receiver uses the slave modport; the pin/handler side uses master.
`timescale 1ns/1ps
interface ps2_key_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic [7:0]  rx_byte;
  logic        byte_stb;
  logic        frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  ps2_key, rx_byte, byte_stb, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output ps2_key, rx_byte, byte_stb, frame_err
  );
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: sync, clock filter, 11-bit framing, E0/F0 prefix decode.
// Optional mid-frame watchdog enabled by defining PS2_TIMEOUT_EN.
`timescale 1ns/1ps
module ps2_key_rx #(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 96000
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  ps2_key_rx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] FILT_MAX = 8'(FILT_LEN - 1);

  function automatic logic is_status(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  logic       clk_sync_p0, clk_sync_p1;
  logic       data_sync_p0, data_sync_p1;
  logic [7:0] filt_cnt;
  logic       clk_filt, clk_filt_d;
  logic       strobe;

  state_t     state, state_nx;
  logic [2:0] bitcnt, bitcnt_nx;
  logic [7:0] shreg;
  logic       par_bit;
  logic       frame_done, frame_ok;
  logic       timeout;
  logic       ext, rel;

  // stage p0/p1: two-flop synchronizers, idle-high after reset
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_p0  <= 1'b1;
      clk_sync_p1  <= 1'b1;
      data_sync_p0 <= 1'b1;
      data_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0  <= bus.ps2_clk;
      clk_sync_p1  <= clk_sync_p0;
      data_sync_p0 <= bus.ps2_data;
      data_sync_p1 <= data_sync_p0;
    end
  end

  // filter stage: the clock must disagree FILT_LEN cycles in a row to flip
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_sync_p1 != clk_filt) begin
        if (filt_cnt == FILT_MAX) begin
          clk_filt <= clk_sync_p1;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 8'd1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign strobe = clk_filt_d & ~clk_filt;

`ifdef PS2_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      wd_cnt <= '0;
    else if (strobe || (state == IDLE) || timeout)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout = (state != IDLE) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      bitcnt <= '0;
    end else begin
      state  <= state_nx;
      bitcnt <= bitcnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bitcnt_nx  = bitcnt;
    frame_done = 1'b0;
    frame_ok   = 1'b0;
    if (timeout) begin
      state_nx = IDLE;
    end else if (strobe) begin
      case (state)
        IDLE: begin
          if (!data_sync_p1) begin
            state_nx  = DATA;
            bitcnt_nx = '0;
          end
        end
        DATA: begin
          bitcnt_nx = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_nx = PARITY;
        end
        PARITY: state_nx = STOP;
        STOP: begin
          state_nx   = IDLE;
          frame_done = 1'b1;
          frame_ok   = data_sync_p1 && (^{shreg, par_bit});
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // datapath capture: LSB-first shifter and parity latch, no reset needed
  always_ff @(posedge clk_sys) begin
    if (strobe && (state == DATA))   shreg   <= {data_sync_p1, shreg[7:1]};
    if (strobe && (state == PARITY)) par_bit <= data_sync_p1;
  end

  // output stage: registered one cycle after the stop-bit strobe
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bus.ps2_key   <= '0;
      bus.rx_byte   <= '0;
      bus.byte_stb  <= 1'b0;
      bus.frame_err <= 1'b0;
      ext           <= 1'b0;
      rel           <= 1'b0;
    end else begin
      bus.byte_stb  <= 1'b0;
      bus.frame_err <= 1'b0;
      if (timeout || (frame_done && !frame_ok)) begin
        bus.frame_err <= 1'b1;
        ext           <= 1'b0;
        rel           <= 1'b0;
      end else if (frame_done) begin
        bus.rx_byte  <= shreg;
        bus.byte_stb <= 1'b1;
        if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          rel <= 1'b1;
        end else if (!is_status(shreg)) begin
          bus.ps2_key <= {~bus.ps2_key[10], ~rel, ext, shreg};
          ext         <= 1'b0;
          rel         <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Randomized bench for ps2_key_rx: drives PS/2 frames and compares against
// a frame-level model of the prefix/event rules.
`timescale 1ns/1ps
module tb_ps2_key_rx;
  localparam int FILT_LEN    = 8;
  localparam int TIMEOUT_CYC = 2000;
  localparam int HALF        = 20;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  ps2_key_rx_if bus();

  ps2_key_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_fail = 0;
  int stb_cnt = 0;
  int err_cnt = 0;
  int evt_lat;

  logic [10:0] m_key;
  logic [7:0]  m_rx;
  bit          m_ext, m_rel;
  logic [7:0]  status_tab [6] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  always @(negedge clk_sys) begin
    if (bus.byte_stb === 1'b1)  stb_cnt <= stb_cnt + 1;
    if (bus.frame_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits, output int lat);
    lat = -1;
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_data = bits[i];
      cycles(HALF);
      bus.ps2_clk = 1'b0;
      for (int c = 1; c <= HALF; c++) begin
        @(negedge clk_sys);
        if (lat < 0 && i == 10 && (bus.byte_stb === 1'b1 || bus.frame_err === 1'b1)) lat = c;
      end
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
    int s0, e0;
    bit ok;
    s0 = stb_cnt;
    e0 = err_cnt;
    ok = !bad_par && !bad_stop;
    send_bits(frame_bits(b, bad_par, bad_stop), 11, evt_lat);
    cycles(2 * HALF);
    if (ok) begin
      m_rx = b;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_rel = 1'b1;
      else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
        m_key = {~m_key[10], ~m_rel, m_ext, b};
        m_ext = 1'b0;
        m_rel = 1'b0;
      end
    end else begin
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
    chk($sformatf("byte_stb_%02h", b), 32'(stb_cnt - s0), ok ? 32'd1 : 32'd0);
    chk($sformatf("frame_err_%02h", b), 32'(err_cnt - e0), ok ? 32'd0 : 32'd1);
    chk($sformatf("rx_byte_%02h", b), 32'(bus.rx_byte), 32'(m_rx));
    chk($sformatf("ps2_key_%02h", b), 32'(bus.ps2_key), 32'(m_key));
  endtask

  task automatic model_reset();
    m_key = '0;
    m_rx  = '0;
    m_ext = 1'b0;
    m_rel = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int lat, s0, e0;
    logic [7:0] b;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset_n      = 1'b0;
    model_reset();
    cycles(5);
    chk("rst_ps2_key", 32'(bus.ps2_key), 32'h0);
    chk("rst_rx_byte", 32'(bus.rx_byte), 32'h0);
    chk("rst_byte_stb", 32'(bus.byte_stb), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    reset_n = 1'b1;
    cycles(5);

    run_frame(8'h1C);
    chk("spec_1c", 32'(bus.ps2_key), 32'h61C);
    chk("latency", 32'(evt_lat), 32'(FILT_LEN + 3));

    run_frame(8'hF0);
    run_frame(8'h1C);
    chk("spec_f0_1c", 32'(bus.ps2_key), 32'h01C);

    run_frame(8'hE0);
    run_frame(8'h75);
    chk("spec_e0_75", 32'(bus.ps2_key), 32'h775);
    run_frame(8'hE0);
    run_frame(8'hF0);
    run_frame(8'h75);
    chk("spec_e0_f0_75", 32'(bus.ps2_key), 32'h175);

    run_frame(8'h29, 1'b1);
    chk("spec_badpar_key", 32'(bus.ps2_key), 32'h175);
    run_frame(8'h29);
    chk("spec_29", 32'(bus.ps2_key), 32'h629);

    run_frame(8'hF0);
    run_frame(8'hE0);
    run_frame(8'h6B);
    chk("spec_f0_e0_6b", 32'(bus.ps2_key), 32'h16B);

    run_frame(8'hE0);
    run_frame(8'hFA);
    run_frame(8'h75);
    chk("status_keeps_ext", 32'(bus.ps2_key), 32'h775);

    // short low glitch with data held low must not start a frame
    s0 = stb_cnt;
    e0 = err_cnt;
    bus.ps2_data = 1'b0;
    bus.ps2_clk  = 1'b0;
    cycles(3);
    bus.ps2_clk  = 1'b1;
    cycles(5);
    bus.ps2_data = 1'b1;
    cycles(40);
    chk("glitch_stb", 32'(stb_cnt - s0), 32'd0);
    chk("glitch_err", 32'(err_cnt - e0), 32'd0);
    run_frame(8'h1C);
    chk("spec_glitch_1c", 32'(bus.ps2_key), 32'h21C);

    // reset after four data bits
    send_bits(frame_bits(8'h1C, 1'b0, 1'b0), 5, lat);
    @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    chk("midrst_ps2_key", 32'(bus.ps2_key), 32'h0);
    chk("midrst_rx_byte", 32'(bus.rx_byte), 32'h0);
    chk("midrst_byte_stb", 32'(bus.byte_stb), 32'h0);
    chk("midrst_frame_err", 32'(bus.frame_err), 32'h0);
    cycles(3);
    reset_n = 1'b1;
    model_reset();
    cycles(5);
    run_frame(8'h1C);
    chk("spec_after_rst", 32'(bus.ps2_key), 32'h61C);

`ifdef PS2_TIMEOUT_EN
    e0 = err_cnt;
    send_bits(frame_bits(8'h1C, 1'b0, 1'b0), 5, lat);
    cycles(TIMEOUT_CYC + 50);
    chk("timeout_err", 32'(err_cnt - e0), 32'd1);
    m_ext = 1'b0;
    m_rel = 1'b0;
    run_frame(8'h1C);
`endif

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = status_tab[$urandom_range(0, 5)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      run_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
